seq_detector_param: RTL and testbench

//  Parametrised Moore serial-pattern detector: watches a 1-bit stream and flags every occurrence of a
//  LEN-bit compile-time pattern. Next generation of the team's fixed 3-bit detector: adds arbitrary

---
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - Moore serial-pattern detector with LEN-bit compile-time pattern.
// Optional saturating match counter enabled by the SEQDET_COUNT_EN macro.

module seq_detector_param #(
   parameter int             LEN     = 3,
   parameter logic [LEN-1:0] PATTERN = 3'b011,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             din,
   input  logic             din_vld,
   input  logic             overlap,
   output logic             y
`ifdef SEQDET_COUNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   localparam int            FW   = $clog2(LEN + 1);
   localparam logic [FW-1:0] FULL = FW'(LEN);

   if (LEN < 2 || LEN > 16 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
      $error("seq_detector_param: LEN must be 2..16 and CNT_W 1..32");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_MATCH = 2'd2
   } state_t;

   state_t          r_state;
   logic [LEN-1:0]  r_hist;
   logic [FW-1:0]   r_fill;
   logic            r_y;

   logic            w_accept;
   logic [LEN-1:0]  w_hist_nxt;
   logic [FW-1:0]   w_fill_inc;
   logic            w_hit;

   assign w_accept   = din_vld && !clr;
   assign w_hist_nxt = {r_hist[LEN-2:0], din};
   assign w_fill_inc = (r_fill >= FULL) ? FULL : r_fill + 1'b1;
   assign w_hit      = (w_fill_inc == FULL) && (w_hist_nxt == PATTERN);
   assign y          = r_y;

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] r_cnt;
   assign match_cnt = r_cnt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_hist  <= '0;
         r_fill  <= '0;
         r_y     <= 1'b0;
`ifdef SEQDET_COUNT_EN
         r_cnt   <= '0;
`endif
      end else if (clr) begin
         r_state <= S_IDLE;
         r_hist  <= '0;
         r_fill  <= '0;
         r_y     <= 1'b0;
`ifdef SEQDET_COUNT_EN
         r_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_FILL, S_MATCH: begin
               if (w_accept) begin
                  r_hist  <= w_hist_nxt;
                  // Non-overlap restarts the window but the hit itself still shows on y.
                  r_fill  <= (w_hit && !overlap) ? '0 : w_fill_inc;
                  r_state <= w_hit ? S_MATCH : S_FILL;
                  r_y     <= w_hit;
`ifdef SEQDET_COUNT_EN
                  if (w_hit && (r_cnt != {CNT_W{1'b1}}))
                     r_cnt <= r_cnt + 1'b1;
`endif
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_hist  <= '0;
               r_fill  <= '0;
               r_y     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - Self-checking bench for seq_detector_param.
// Four instances share one stimulus stream and are checked against a bench-side reference model.

module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr;
   logic       din;
   logic       din_vld;
   logic       overlap;
   logic [3:0] y;

   always #5 clk = ~clk;

`ifdef SEQDET_COUNT_EN
   logic [7:0] cnt0, cnt1, cnt3;
   logic [1:0] cnt2;
`endif

   seq_detector_param #(.LEN(3), .PATTERN(3'b011), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .clr(clr), .din(din), .din_vld(din_vld),
      .overlap(overlap), .y(y[0])
`ifdef SEQDET_COUNT_EN
      , .match_cnt(cnt0)
`endif
   );
   seq_detector_param #(.LEN(3), .PATTERN(3'b111), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .clr(clr), .din(din), .din_vld(din_vld),
      .overlap(overlap), .y(y[1])
`ifdef SEQDET_COUNT_EN
      , .match_cnt(cnt1)
`endif
   );
   seq_detector_param #(.LEN(3), .PATTERN(3'b011), .CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .clr(clr), .din(din), .din_vld(din_vld),
      .overlap(overlap), .y(y[2])
`ifdef SEQDET_COUNT_EN
      , .match_cnt(cnt2)
`endif
   );
   seq_detector_param #(.LEN(5), .PATTERN(5'b10110), .CNT_W(8)) u3 (
      .clk(clk), .reset(reset), .clr(clr), .din(din), .din_vld(din_vld),
      .overlap(overlap), .y(y[3])
`ifdef SEQDET_COUNT_EN
      , .match_cnt(cnt3)
`endif
   );

   // Reference model: the last m_len bits of the accepted stream, and how many fresh bits are in the window.
   int   m_len [4] = '{3, 3, 3, 5};
   int   m_pat [4] = '{3, 7, 3, 22};
   int   m_max [4] = '{255, 255, 3, 255};
   int   m_bits[4];
   int   m_fresh[4];
   int   m_cnt [4];
   logic m_y   [4];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_bits[i] = 0; m_fresh[i] = 0; m_cnt[i] = 0; m_y[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit hit;
      if (clr) model_clear();
      else if (din_vld) begin
         for (int i = 0; i < 4; i++) begin
            m_bits[i]  = (m_bits[i] * 2 + int'(din)) % (1 << m_len[i]);
            m_fresh[i] = (m_fresh[i] + 1 > m_len[i]) ? m_len[i] : m_fresh[i] + 1;
            hit        = (m_fresh[i] == m_len[i]) && (m_bits[i] == m_pat[i]);
            if (hit && !overlap) m_fresh[i] = 0;
            m_y[i] = hit;
            if (hit && m_cnt[i] < m_max[i]) m_cnt[i]++;
         end
      end
   endtask

   function automatic logic [31:0] dut_cnt(input int i);
`ifdef SEQDET_COUNT_EN
      case (i)
         0:       return 32'(cnt0);
         1:       return 32'(cnt1);
         2:       return 32'(cnt2);
         default: return 32'(cnt3);
      endcase
`else
      return 32'(i) & 32'd0;
`endif
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s.y%0d", tag, i), 32'(y[i]), 32'(m_y[i]));
`ifdef SEQDET_COUNT_EN
         chk($sformatf("%s.cnt%0d", tag, i), dut_cnt(i), 32'(m_cnt[i]));
`endif
      end
   endtask

   task automatic step(input string tag, input logic d, input logic v, input logic c, input logic o);
      din = d; din_vld = v; clr = c; overlap = o;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic pulse_reset(input string tag);
      #2 reset = 1'b1;
      model_clear();
      #1 check_all({tag, ".in_rst"});
      #1 reset = 1'b0;
   endtask

   initial begin
      logic [4:0] seq5;
      reset = 1'b1; clr = 1'b0; din = 1'b0; din_vld = 1'b0; overlap = 1'b1;
      model_clear();
      #3 check_all("reset");
      @(posedge clk); #1 reset = 1'b0;

      // 1: 0,1,1 -> match, then 0 -> drop
      step("t1a", 0, 1, 0, 1); step("t1b", 1, 1, 0, 1); step("t1c", 1, 1, 0, 1);
      chk("t1.y", 32'(y[0]), 32'd1);
      chk("t1.cnt", dut_cnt(0), `ifdef SEQDET_COUNT_EN 32'd1 `else 32'd0 `endif);
      step("t1d", 0, 1, 0, 1);
      chk("t1.y_drop", 32'(y[0]), 32'd0);

      // 2: 11111 on pattern 111, overlap then non-overlap
      pulse_reset("t2");
      for (int k = 0; k < 5; k++) begin
         step("t2o", 1, 1, 0, 1);
         chk("t2o.y", 32'(y[1]), (k >= 2) ? 32'd1 : 32'd0);
      end
      chk("t2o.cnt", dut_cnt(1), `ifdef SEQDET_COUNT_EN 32'd3 `else 32'd0 `endif);
      pulse_reset("t2n");
      for (int k = 0; k < 5; k++) begin
         step("t2n", 1, 1, 0, 0);
         chk("t2n.y", 32'(y[1]), (k == 2) ? 32'd1 : 32'd0);
      end
      chk("t2n.cnt", dut_cnt(1), `ifdef SEQDET_COUNT_EN 32'd1 `else 32'd0 `endif);

      // 3: gaps in din_vld, y held while idle
      pulse_reset("t3");
      step("t3", 0, 1, 0, 1); step("t3", 1, 0, 0, 1); step("t3", 1, 0, 0, 1);
      step("t3", 1, 1, 0, 1); step("t3", 0, 0, 0, 1); step("t3", 1, 1, 0, 1);
      for (int k = 0; k < 3; k++) begin
         step("t3h", 0, 0, 0, 1);
         chk("t3.hold", 32'(y[0]), 32'd1);
      end

      // 4: prefix fallback
      pulse_reset("t4a");
      seq5 = 5'b00011;
      for (int k = 1; k < 5; k++) begin
         step("t4a", seq5[4-k], 1, 0, 1);
         chk("t4a.y", 32'(y[0]), (k == 4) ? 32'd1 : 32'd0);
      end
      pulse_reset("t4b");
      seq5 = 5'b01011;
      for (int k = 0; k < 5; k++) begin
         step("t4b", seq5[4-k], 1, 0, 1);
         chk("t4b.y", 32'(y[0]), (k == 4) ? 32'd1 : 32'd0);
      end

      // 5: async reset mid-stream, then clr beats a completing bit
      pulse_reset("t5");
      step("t5", 0, 1, 0, 1); step("t5", 1, 1, 0, 1);
      pulse_reset("t5r");
      chk("t5.y_rst", 32'(y[0]), 32'd0);
      step("t5", 1, 1, 0, 1);
      chk("t5.nomatch", 32'(y[0]), 32'd0);
      step("t5", 0, 1, 0, 1); step("t5", 1, 1, 0, 1); step("t5c", 1, 1, 1, 1);
      chk("t5.clr", 32'(y[0]), 32'd0);

      // 6: CNT_W=2 saturation with non-overlap matches
      pulse_reset("t6");
      for (int m = 0; m < 5; m++) begin
         step("t6", 0, 1, 0, 0); step("t6", 1, 1, 0, 0); step("t6", 1, 1, 0, 0);
         chk("t6.y", 32'(y[2]), 32'd1);
`ifdef SEQDET_COUNT_EN
         chk("t6.cnt", 32'(cnt2), (m < 3) ? 32'(m + 1) : 32'd3);
`endif
      end

      // Random stream against the model
      pulse_reset("rnd");
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
         step("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
